// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares one single-port framebuffer RAM between the display fetch engine
//   (priority requester) and the CPU Avalon-MM data port. A saturating
//   starvation counter forces a CPU slot after STARVE_LIMIT consecutive denied
//   cycles. Read returns are routed back to their owner by a valid/owner tag
//   pipeline matched to the fixed memory read latency.
//
// Ports
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   disp_req/disp_addr          display read request (held until granted)
//   disp_grant                  combinational accept for the display
//   disp_rdata/disp_rvalid      display read return
//   cpu_read/cpu_write/...      Avalon-MM slave side for the CPU
//   cpu_waitrequest             combinational, low = CPU request accepted
//   cpu_readdata/..valid        CPU read return
//   mem_addr/mem_wdata/mem_we/mem_re   registered RAM command
//   mem_rdata                   RAM read data, RD_LAT cycles after mem_re
module fb_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_grant,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_waitrequest,
  output logic [DW-1:0] cpu_readdata,
  output logic          cpu_readdatavalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  logic          cpu_pend;
  logic          cpu_win;
  logic          disp_win;
  logic          issue_read;
  logic [7:0]    starve_cnt;

  // Tag stage 0 is loaded with the issue; stage RD_LAT lines up with the
  // cycle in which mem_rdata is valid for that read.
  logic [RD_LAT:0] tag_valid;
  logic [RD_LAT:0] tag_cpu;

  assign cpu_pend = cpu_read | cpu_write;

  // Grants are forced off while reset is held so the CPU sees waitrequest=1.
  assign cpu_win  = reset_reset_n & cpu_pend &
                    (~disp_req | (starve_cnt >= 8'(STARVE_LIMIT)));
  assign disp_win = reset_reset_n & disp_req & ~cpu_win;

  // A simultaneous read+write from the CPU is handled as a write only.
  assign issue_read = disp_win | (cpu_win & ~cpu_write);

  assign disp_grant      = disp_win;
  assign cpu_waitrequest = ~cpu_win;

  // Memory command register: one operation per cycle, high for one cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      mem_re <= issue_read;
      mem_we <= cpu_win & cpu_write;
      if (disp_win) begin
        mem_addr  <= disp_addr;
        mem_wdata <= '0;
      end else if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_write ? cpu_wdata : '0;
      end
    end
  end

  // Saturating count of consecutive cycles the CPU was pending but denied.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      starve_cnt <= '0;
    end else if (cpu_win || !cpu_pend) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Latency-matched tag shift register; clearing it on reset drops any
  // in-flight reads so they never raise an rvalid.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tag_valid <= '0;
      tag_cpu   <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LAT-1:0], issue_read};
      tag_cpu   <= {tag_cpu[RD_LAT-1:0], cpu_win};
    end
  end

  // Return register: only the owner's data register captures mem_rdata,
  // the other keeps its previous value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      disp_rdata        <= '0;
      disp_rvalid       <= 1'b0;
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
    end else begin
      disp_rvalid       <= tag_valid[RD_LAT] & ~tag_cpu[RD_LAT];
      cpu_readdatavalid <= tag_valid[RD_LAT] &  tag_cpu[RD_LAT];
      if (tag_valid[RD_LAT]) begin
        if (tag_cpu[RD_LAT]) begin
          cpu_readdata <= mem_rdata;
        end else begin
          disp_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
